// File: rtl/issue_pkg.sv
// Shared types for the dual-issue scheduler: FSM states, widths and the
// per-slot decode bundle that decode hands over for every instruction.
package issue_pkg;

    localparam int ISSUE_NUM_REGS = 32;
    localparam int ISSUE_RADDR_W  = 5;

    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic [ISSUE_RADDR_W-1:0] raddr1;
        logic [ISSUE_RADDR_W-1:0] raddr2;
        logic [ISSUE_RADDR_W-1:0] dest;
        logic                     gr_we;
        logic                     res_from_mem;
        logic                     mem_we;
        logic                     is_mul;
        logic                     is_br;
    } inst_dec_t;

    function automatic logic is_mem(input inst_dec_t i);
        return i.res_from_mem | i.mem_we;
    endfunction

    // Long-latency producers are tracked until their writeback clears them.
    function automatic logic sets_busy(input inst_dec_t i);
        return i.gr_we & (i.res_from_mem | i.is_mul) & (i.dest != '0);
    endfunction

    function automatic logic must_split(
        input inst_dec_t a,
        input inst_dec_t b
    );
        logic raw;
        logic waw;
        raw = a.gr_we & (a.dest != '0)
            & ((a.dest == b.raddr1) | (a.dest == b.raddr2));
        waw = a.gr_we & b.gr_we & (a.dest != '0)
            & (a.dest == b.dest);
        return raw | waw
             | (is_mem(a) & is_mem(b))
             | (a.is_mul & b.is_mul)
             | (a.is_br & b.is_br);
    endfunction

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Decode/execute/writeback bundle seen by the issue scheduler.
// master = the surrounding pipeline, slave = the scheduler.
interface dual_issue_ctrl_if;
    import issue_pkg::*;

    logic                     pair_valid_i;
    logic                     inst1_valid_i;
    logic                     inst2_valid_i;
    logic [ISSUE_RADDR_W-1:0] inst1_rf_raddr1_i;
    logic [ISSUE_RADDR_W-1:0] inst1_rf_raddr2_i;
    logic [ISSUE_RADDR_W-1:0] inst1_dest_i;
    logic                     inst1_gr_we_i;
    logic                     inst1_res_from_mem_i;
    logic                     inst1_mem_we_i;
    logic                     inst1_is_mul_i;
    logic                     inst1_is_br_i;
    logic [ISSUE_RADDR_W-1:0] inst2_rf_raddr1_i;
    logic [ISSUE_RADDR_W-1:0] inst2_rf_raddr2_i;
    logic [ISSUE_RADDR_W-1:0] inst2_dest_i;
    logic                     inst2_gr_we_i;
    logic                     inst2_res_from_mem_i;
    logic                     inst2_mem_we_i;
    logic                     inst2_is_mul_i;
    logic                     inst2_is_br_i;
    logic                     ex_ready_i;
    logic                     flush_i;
    logic [1:0]               wb_clr_valid_i;
    logic [ISSUE_RADDR_W-1:0] wb_clr_addr0_i;
    logic [ISSUE_RADDR_W-1:0] wb_clr_addr1_i;
    logic                     pair_ready_o;
    logic                     slot0_valid_o;
    logic                     slot0_is_inst2_o;
    logic                     slot1_valid_o;

    modport master (
        output pair_valid_i, inst1_valid_i, inst2_valid_i,
        output inst1_rf_raddr1_i, inst1_rf_raddr2_i, inst1_dest_i,
        output inst1_gr_we_i, inst1_res_from_mem_i, inst1_mem_we_i,
        output inst1_is_mul_i, inst1_is_br_i,
        output inst2_rf_raddr1_i, inst2_rf_raddr2_i, inst2_dest_i,
        output inst2_gr_we_i, inst2_res_from_mem_i, inst2_mem_we_i,
        output inst2_is_mul_i, inst2_is_br_i,
        output ex_ready_i, flush_i,
        output wb_clr_valid_i, wb_clr_addr0_i, wb_clr_addr1_i,
        input  pair_ready_o, slot0_valid_o, slot0_is_inst2_o,
        input  slot1_valid_o
    );

    modport slave (
        input  pair_valid_i, inst1_valid_i, inst2_valid_i,
        input  inst1_rf_raddr1_i, inst1_rf_raddr2_i, inst1_dest_i,
        input  inst1_gr_we_i, inst1_res_from_mem_i, inst1_mem_we_i,
        input  inst1_is_mul_i, inst1_is_br_i,
        input  inst2_rf_raddr1_i, inst2_rf_raddr2_i, inst2_dest_i,
        input  inst2_gr_we_i, inst2_res_from_mem_i, inst2_mem_we_i,
        input  inst2_is_mul_i, inst2_is_br_i,
        input  ex_ready_i, flush_i,
        input  wb_clr_valid_i, wb_clr_addr0_i, wb_clr_addr1_i,
        output pair_ready_o, slot0_valid_o, slot0_is_inst2_o,
        output slot1_valid_o
    );

endinterface

// File: rtl/issue_scoreboard.sv
// Busy bit per GPR for in-flight load/mul results; readiness is read
// from the registered vector only, so a clear is visible one cycle later.
module issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int RADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [1:0]         set_valid_i,
    input  logic [RADDR_W-1:0] set_addr0_i,
    input  logic [RADDR_W-1:0] set_addr1_i,
    input  logic [1:0]         clr_valid_i,
    input  logic [RADDR_W-1:0] clr_addr0_i,
    input  logic [RADDR_W-1:0] clr_addr1_i,
    input  logic [RADDR_W-1:0] q0_addr1_i,
    input  logic [RADDR_W-1:0] q0_addr2_i,
    input  logic [RADDR_W-1:0] q1_addr1_i,
    input  logic [RADDR_W-1:0] q1_addr2_i,
    output logic               q0_rdy_o,
    output logic               q1_rdy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    function automatic logic is_free(
        input logic [RADDR_W-1:0]  a,
        input logic [NUM_REGS-1:0] b
    );
        return (a == '0) | ~b[a];
    endfunction

    // Clears first, then sets, so a same-cycle set keeps the bit busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_valid_i[0] && clr_addr0_i == RADDR_W'(i))
                busy_d[i] = 1'b0;
            if (clr_valid_i[1] && clr_addr1_i == RADDR_W'(i))
                busy_d[i] = 1'b0;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (set_valid_i[0] && set_addr0_i == RADDR_W'(i))
                busy_d[i] = 1'b1;
            if (set_valid_i[1] && set_addr1_i == RADDR_W'(i))
                busy_d[i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush_i)
            busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign q0_rdy_o = is_free(q0_addr1_i, busy_q)
                    & is_free(q0_addr2_i, busy_q);
    assign q1_rdy_o = is_free(q1_addr1_i, busy_q)
                    & is_free(q1_addr2_i, busy_q);

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue scheduler: pairs, splits or stalls the decoded pair and holds
// the registered slot descriptor consumed by the execute pipes.
module dual_issue_ctrl
    import issue_pkg::*;
#(
    parameter int NUM_REGS = ISSUE_NUM_REGS,
    parameter int RADDR_W  = ISSUE_RADDR_W
) (
    input logic               clk,
    input logic               rst,
    dual_issue_ctrl_if.slave  io
);

    localparam logic [0:0] FIRST  = ST_FIRST;
    localparam logic [0:0] SECOND = ST_SECOND;

    logic [0:0] state_q, state_d;
    logic       slot0_valid_q, slot0_valid_d;
    logic       slot0_is_inst2_q, slot0_is_inst2_d;
    logic       slot1_valid_q, slot1_valid_d;

    inst_dec_t  i1, i2;
    logic       v1, v2, rdy1, rdy2, split, go;
    logic       iss1, iss2, iss_dual, pair_ready;
    logic [1:0] set_valid;
    logic [RADDR_W-1:0] set_addr0;

    assign i1 = '{
        raddr1: io.inst1_rf_raddr1_i,
        raddr2: io.inst1_rf_raddr2_i,
        dest: io.inst1_dest_i,
        gr_we: io.inst1_gr_we_i,
        res_from_mem: io.inst1_res_from_mem_i,
        mem_we: io.inst1_mem_we_i,
        is_mul: io.inst1_is_mul_i,
        is_br: io.inst1_is_br_i
    };

    assign i2 = '{
        raddr1: io.inst2_rf_raddr1_i,
        raddr2: io.inst2_rf_raddr2_i,
        dest: io.inst2_dest_i,
        gr_we: io.inst2_gr_we_i,
        res_from_mem: io.inst2_res_from_mem_i,
        mem_we: io.inst2_mem_we_i,
        is_mul: io.inst2_is_mul_i,
        is_br: io.inst2_is_br_i
    };

    always_comb begin
        v1 = io.pair_valid_i & io.inst1_valid_i & (state_q == FIRST);
        v2 = io.pair_valid_i & io.inst2_valid_i;
        split = must_split(i1, i2);
        go = io.ex_ready_i & ~io.flush_i & ~rst;
        iss1 = 1'b0;
        iss2 = 1'b0;
        iss_dual = 1'b0;
        pair_ready = 1'b0;
        state_d = state_q;
        if (go) begin
            unique case (1'b1)
                (state_q == SECOND): begin
                    if (v2 & rdy2) begin
                        iss2 = 1'b1;
                        pair_ready = 1'b1;
                        state_d = FIRST;
                    end
                end
                v1: begin
                    if (rdy1) begin
                        iss1 = 1'b1;
                        if (v2 & rdy2 & ~split) begin
                            iss_dual = 1'b1;
                            pair_ready = 1'b1;
                        end else if (v2) begin
                            state_d = SECOND;
                        end else begin
                            pair_ready = 1'b1;
                        end
                    end
                end
                ((state_q == FIRST) & ~io.inst1_valid_i & v2): begin
                    if (rdy2) begin
                        iss2 = 1'b1;
                        pair_ready = 1'b1;
                    end
                end
                ((state_q == FIRST) & io.pair_valid_i
                  & ~io.inst1_valid_i & ~io.inst2_valid_i): begin
                    pair_ready = 1'b1;
                end
                default: ;
            endcase
        end
        if (io.flush_i)
            state_d = FIRST;
    end

    // A stalled execute stage keeps the descriptor; otherwise it reloads,
    // which turns into a bubble when nothing issued this cycle.
    always_comb begin
        slot0_valid_d = slot0_valid_q;
        slot0_is_inst2_d = slot0_is_inst2_q;
        slot1_valid_d = slot1_valid_q;
        if (io.flush_i) begin
            slot0_valid_d = 1'b0;
            slot0_is_inst2_d = 1'b0;
            slot1_valid_d = 1'b0;
        end else if (io.ex_ready_i) begin
            slot0_valid_d = iss1 | iss2;
            slot0_is_inst2_d = iss2;
            slot1_valid_d = iss_dual;
        end
    end

    always_comb begin
        set_valid[0] = (iss1 & sets_busy(i1)) | (iss2 & sets_busy(i2));
        set_valid[1] = iss_dual & sets_busy(i2);
        set_addr0 = iss2 ? i2.dest : i1.dest;
    end

    issue_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .RADDR_W  (RADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (io.flush_i),
        .set_valid_i (set_valid),
        .set_addr0_i (set_addr0),
        .set_addr1_i (i2.dest),
        .clr_valid_i (io.wb_clr_valid_i),
        .clr_addr0_i (io.wb_clr_addr0_i),
        .clr_addr1_i (io.wb_clr_addr1_i),
        .q0_addr1_i  (i1.raddr1),
        .q0_addr2_i  (i1.raddr2),
        .q1_addr1_i  (i2.raddr1),
        .q1_addr2_i  (i2.raddr2),
        .q0_rdy_o    (rdy1),
        .q1_rdy_o    (rdy2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FIRST;
            slot0_valid_q <= 1'b0;
            slot0_is_inst2_q <= 1'b0;
            slot1_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot0_valid_q <= slot0_valid_d;
            slot0_is_inst2_q <= slot0_is_inst2_d;
            slot1_valid_q <= slot1_valid_d;
        end
    end

    assign io.pair_ready_o = pair_ready;
    assign io.slot0_valid_o = slot0_valid_q;
    assign io.slot0_is_inst2_o = slot0_is_inst2_q;
    assign io.slot1_valid_o = slot1_valid_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed scenarios plus a randomized run
// against a pair-level reference model of issue and scoreboard rules.
module tb_dual_issue_ctrl;
    import issue_pkg::*;

    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_MUL = 3;
    localparam int K_BR  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_issue_ctrl_if bus();

    dual_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int total = 0;
    int bad = 0;

    bit m_second;
    bit m_busy[32];
    bit m_s0v, m_s0i2, m_s1v;

    function automatic inst_dec_t mk(int kind, int rd, int rj, int rk);
        inst_dec_t x;
        x = '0;
        x.raddr1 = 5'(rj);
        x.raddr2 = 5'(rk);
        x.dest = 5'(rd);
        case (kind)
            K_ALU: x.gr_we = 1'b1;
            K_LD: begin
                x.gr_we = 1'b1;
                x.res_from_mem = 1'b1;
            end
            K_ST: begin
                x.mem_we = 1'b1;
                x.raddr2 = 5'(rd);
                x.dest = 5'(0);
            end
            K_MUL: begin
                x.gr_we = 1'b1;
                x.is_mul = 1'b1;
            end
            K_BR: begin
                x.is_br = 1'b1;
                x.gr_we = (rd != 0);
            end
            default: ;
        endcase
        return x;
    endfunction

    task automatic drive(bit pv, bit v1, bit v2,
                         inst_dec_t a, inst_dec_t b);
        bus.pair_valid_i = pv;
        bus.inst1_valid_i = v1;
        bus.inst2_valid_i = v2;
        bus.inst1_rf_raddr1_i = a.raddr1;
        bus.inst1_rf_raddr2_i = a.raddr2;
        bus.inst1_dest_i = a.dest;
        bus.inst1_gr_we_i = a.gr_we;
        bus.inst1_res_from_mem_i = a.res_from_mem;
        bus.inst1_mem_we_i = a.mem_we;
        bus.inst1_is_mul_i = a.is_mul;
        bus.inst1_is_br_i = a.is_br;
        bus.inst2_rf_raddr1_i = b.raddr1;
        bus.inst2_rf_raddr2_i = b.raddr2;
        bus.inst2_dest_i = b.dest;
        bus.inst2_gr_we_i = b.gr_we;
        bus.inst2_res_from_mem_i = b.res_from_mem;
        bus.inst2_mem_we_i = b.mem_we;
        bus.inst2_is_mul_i = b.is_mul;
        bus.inst2_is_br_i = b.is_br;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0);
    endtask

    task automatic clr(bit [1:0] v, int a0, int a1);
        bus.wb_clr_valid_i = v;
        bus.wb_clr_addr0_i = 5'(a0);
        bus.wb_clr_addr1_i = 5'(a1);
    endtask

    function automatic inst_dec_t cur1();
        inst_dec_t x;
        x.raddr1 = bus.inst1_rf_raddr1_i;
        x.raddr2 = bus.inst1_rf_raddr2_i;
        x.dest = bus.inst1_dest_i;
        x.gr_we = bus.inst1_gr_we_i;
        x.res_from_mem = bus.inst1_res_from_mem_i;
        x.mem_we = bus.inst1_mem_we_i;
        x.is_mul = bus.inst1_is_mul_i;
        x.is_br = bus.inst1_is_br_i;
        return x;
    endfunction

    function automatic inst_dec_t cur2();
        inst_dec_t x;
        x.raddr1 = bus.inst2_rf_raddr1_i;
        x.raddr2 = bus.inst2_rf_raddr2_i;
        x.dest = bus.inst2_dest_i;
        x.gr_we = bus.inst2_gr_we_i;
        x.res_from_mem = bus.inst2_res_from_mem_i;
        x.mem_we = bus.inst2_mem_we_i;
        x.is_mul = bus.inst2_is_mul_i;
        x.is_br = bus.inst2_is_br_i;
        return x;
    endfunction

    function automatic bit srcs_free(inst_dec_t x);
        bit b1, b2;
        b1 = (x.raddr1 != 0) && m_busy[x.raddr1];
        b2 = (x.raddr2 != 0) && m_busy[x.raddr2];
        return !(b1 || b2);
    endfunction

    function automatic bit can_pair(inst_dec_t a, inst_dec_t b);
        bit am, bm;
        am = a.res_from_mem || a.mem_we;
        bm = b.res_from_mem || b.mem_we;
        if (a.gr_we && a.dest != 0 &&
            (a.dest == b.raddr1 || a.dest == b.raddr2)) return 0;
        if (am && bm) return 0;
        if (a.is_mul && b.is_mul) return 0;
        if (a.is_br && b.is_br) return 0;
        if (a.gr_we && b.gr_we && a.dest != 0 && a.dest == b.dest)
            return 0;
        return 1;
    endfunction

    function automatic bit long_lat(inst_dec_t x);
        return x.gr_we && (x.res_from_mem || x.is_mul) && x.dest != 0;
    endfunction

    // One clock: model predicts pair_ready and the next slot descriptor.
    task automatic tick(output logic [3:0] exp_v,
                        output logic [3:0] got_v);
        inst_dec_t a, b, x;
        int issued[$];
        bit pr, got_pr, h1, h2;
        bit nb[32];
        #2;
        a = cur1();
        b = cur2();
        got_pr = bus.pair_ready_o;
        pr = 0;
        nb = m_busy;
        if (rst || bus.flush_i) begin
            m_second = 0;
            {m_s0v, m_s0i2, m_s1v} = 3'b000;
            nb = '{default: 0};
        end else begin
            if (bus.ex_ready_i) begin
                h1 = bus.pair_valid_i && bus.inst1_valid_i && !m_second;
                h2 = bus.pair_valid_i && bus.inst2_valid_i;
                if (m_second) begin
                    if (h2 && srcs_free(b)) begin
                        issued.push_back(2);
                        pr = 1;
                        m_second = 0;
                    end
                end else if (h1) begin
                    if (srcs_free(a)) begin
                        issued.push_back(1);
                        if (h2 && srcs_free(b) && can_pair(a, b)) begin
                            issued.push_back(2);
                            pr = 1;
                        end else if (h2) m_second = 1;
                        else pr = 1;
                    end
                end else if (h2) begin
                    if (srcs_free(b)) begin
                        issued.push_back(2);
                        pr = 1;
                    end
                end else if (bus.pair_valid_i) pr = 1;
                m_s0v = issued.size() > 0;
                m_s0i2 = issued.size() == 1 && issued[0] == 2;
                m_s1v = issued.size() == 2;
            end
            if (bus.wb_clr_valid_i[0]) nb[bus.wb_clr_addr0_i] = 0;
            if (bus.wb_clr_valid_i[1]) nb[bus.wb_clr_addr1_i] = 0;
            foreach (issued[k]) begin
                x = (issued[k] == 1) ? a : b;
                if (long_lat(x)) nb[x.dest] = 1;
            end
        end
        @(posedge clk);
        m_busy = nb;
        #1;
        exp_v = {pr, m_s0v, m_s0i2, m_s1v};
        got_v = {got_pr, bus.slot0_valid_o, bus.slot0_is_inst2_o,
                 bus.slot1_valid_o};
    endtask

    task automatic test_reset();
        logic [3:0] e, g;
        rst = 1;
        drive(1, 1, 1, mk(K_ALU, 3, 1, 2), mk(K_ALU, 5, 4, 6));
        tick(e, g);
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL reset_busy got=%b exp=0000", g);
        end
        idle();
        tick(e, g);
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=0000", g);
        end
        rst = 0;
        tick(e, g);
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release got=%b exp=0000", g);
        end
    endtask

    task automatic test_dual();
        logic [3:0] e, g;
        drive(1, 1, 1, mk(K_ALU, 3, 1, 2), mk(K_ALU, 5, 4, 6));
        tick(e, g);
        total++;
        if (g !== 4'b1101) begin
            bad++;
            $display("FAIL dual got=%b exp=1101", g);
        end
        drive(1, 0, 0, '0, '0);
        tick(e, g);
        total++;
        if (g !== 4'b1000) begin
            bad++;
            $display("FAIL empty_pair got=%b exp=1000", g);
        end
        idle();
        tick(e, g);
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL bubble got=%b exp=0000", g);
        end
    endtask

    task automatic test_raw_split();
        logic [3:0] e, g;
        drive(1, 1, 1, mk(K_ALU, 3, 1, 2), mk(K_ALU, 7, 3, 2));
        tick(e, g);
        total++;
        if (g !== 4'b0100) begin
            bad++;
            $display("FAIL raw_first got=%b exp=0100", g);
        end
        tick(e, g);
        total++;
        if (g !== 4'b1110) begin
            bad++;
            $display("FAIL raw_second got=%b exp=1110", g);
        end
        idle();
        tick(e, g);
    endtask

    task automatic test_load_stall();
        logic [3:0] e, g;
        drive(1, 1, 0, mk(K_LD, 4, 1, 0), '0);
        tick(e, g);
        total++;
        if (g !== 4'b1100) begin
            bad++;
            $display("FAIL ld_issue got=%b exp=1100", g);
        end
        drive(1, 1, 0, mk(K_ALU, 5, 4, 1), '0);
        for (int i = 0; i < 2; i++) begin
            tick(e, g);
            total++;
            if (g !== 4'b0000) begin
                bad++;
                $display("FAIL ld_stall%0d got=%b exp=0000", i, g);
            end
        end
        clr(2'b01, 4, 0);
        tick(e, g);
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL clr_cycle got=%b exp=0000", g);
        end
        clr(2'b00, 0, 0);
        tick(e, g);
        total++;
        if (g !== 4'b1100) begin
            bad++;
            $display("FAIL after_clr got=%b exp=1100", g);
        end
        idle();
        tick(e, g);
    endtask

    task automatic test_mem_pairs();
        logic [3:0] e, g;
        drive(1, 1, 1, mk(K_LD, 4, 1, 0), mk(K_LD, 8, 2, 0));
        tick(e, g);
        total++;
        if (g !== 4'b0100) begin
            bad++;
            $display("FAIL ld_ld_first got=%b exp=0100", g);
        end
        tick(e, g);
        total++;
        if (g !== 4'b1110) begin
            bad++;
            $display("FAIL ld_ld_second got=%b exp=1110", g);
        end
        idle();
        clr(2'b11, 4, 8);
        tick(e, g);
        clr(2'b00, 0, 0);
        drive(1, 1, 1, mk(K_ST, 9, 1, 0), mk(K_ALU, 5, 6, 7));
        tick(e, g);
        total++;
        if (g !== 4'b1101) begin
            bad++;
            $display("FAIL st_alu got=%b exp=1101", g);
        end
        idle();
        tick(e, g);
    endtask

    task automatic test_flush();
        logic [3:0] e, g;
        drive(1, 1, 0, mk(K_LD, 10, 1, 0), '0);
        tick(e, g);
        drive(1, 1, 1, mk(K_ALU, 3, 1, 2), mk(K_ALU, 7, 3, 2));
        tick(e, g);
        total++;
        if (g !== 4'b0100) begin
            bad++;
            $display("FAIL fl_split got=%b exp=0100", g);
        end
        bus.flush_i = 1;
        tick(e, g);
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL flush got=%b exp=0000", g);
        end
        bus.flush_i = 0;
        tick(e, g);
        total++;
        if (g !== 4'b0100) begin
            bad++;
            $display("FAIL fl_restart got=%b exp=0100", g);
        end
        tick(e, g);
        drive(1, 1, 0, mk(K_ALU, 11, 10, 1), '0);
        tick(e, g);
        total++;
        if (g !== 4'b1100) begin
            bad++;
            $display("FAIL fl_sb_clear got=%b exp=1100", g);
        end
        idle();
        tick(e, g);
    endtask

    task automatic test_ex_stall();
        logic [3:0] e, g;
        drive(1, 1, 1, mk(K_ALU, 3, 1, 2), mk(K_ALU, 5, 4, 6));
        tick(e, g);
        drive(1, 0, 1, '0, mk(K_ALU, 12, 1, 2));
        bus.ex_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick(e, g);
            total++;
            if (g !== 4'b0101) begin
                bad++;
                $display("FAIL ex_hold%0d got=%b exp=0101", i, g);
            end
        end
        bus.ex_ready_i = 1;
        tick(e, g);
        total++;
        if (g !== 4'b1110) begin
            bad++;
            $display("FAIL ex_resume got=%b exp=1110", g);
        end
        idle();
        tick(e, g);
    endtask

    task automatic test_set_clr_same();
        logic [3:0] e, g;
        drive(1, 1, 0, mk(K_LD, 4, 1, 0), '0);
        clr(2'b01, 4, 0);
        tick(e, g);
        clr(2'b00, 0, 0);
        drive(1, 1, 0, mk(K_ALU, 5, 4, 1), '0);
        tick(e, g);
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL set_wins got=%b exp=0000", g);
        end
        clr(2'b10, 0, 4);
        tick(e, g);
        clr(2'b00, 0, 0);
        tick(e, g);
        total++;
        if (g !== 4'b1100) begin
            bad++;
            $display("FAIL set_wins_release got=%b exp=1100", g);
        end
        idle();
        tick(e, g);
    endtask

    task automatic test_random();
        logic [3:0] e, g;
        bit need_new;
        int ka, kb;
        need_new = 1;
        for (int n = 0; n < 600; n++) begin
            if (need_new) begin
                ka = $urandom_range(0, 4);
                kb = $urandom_range(0, 4);
                drive($urandom_range(0, 4) != 0,
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0,
                      mk(ka, $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7)),
                      mk(kb, $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7)));
            end
            bus.ex_ready_i = $urandom_range(0, 5) != 0;
            bus.flush_i = $urandom_range(0, 24) == 0;
            clr(2'($urandom_range(0, 3)), $urandom_range(0, 7),
                $urandom_range(0, 7));
            need_new = !bus.pair_valid_i || bus.flush_i;
            tick(e, g);
            if (e[3]) need_new = 1;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL random%0d got=%b exp=%b", n, g, e);
            end
        end
        bus.flush_i = 0;
        bus.ex_ready_i = 1;
        clr(2'b00, 0, 0);
        idle();
    endtask

    initial begin
        idle();
        clr(2'b00, 0, 0);
        bus.ex_ready_i = 1;
        bus.flush_i = 0;
        m_second = 0;
        m_busy = '{default: 0};
        {m_s0v, m_s0i2, m_s1v} = 3'b000;
        test_reset();
        test_dual();
        test_raw_split();
        test_load_stall();
        test_mem_pairs();
        test_flush();
        test_ex_stall();
        test_set_clr_same();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
